// File: rtl/lpm_mux_reg_n_if.sv
// Request/readback bundle of the registered N:1 read-data mux.
// The master side issues requests and consumes words; the slave side is the mux.
interface lpm_mux_reg_n_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]          sel;
    logic                      mode;
    logic                      req_valid;
    logic                      req_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_err;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output data_in, sel, mode, req_valid, out_ready,
        input  req_ready, out_data, out_ch, out_err, out_valid
    );

    modport slave (
        input  data_in, sel, mode, req_valid, out_ready,
        output req_ready, out_data, out_ch, out_err, out_valid
    );
endinterface

// File: rtl/lpm_mux_reg_n.sv
// Registered N:1 read-data mux with direct-select and auto-scan modes.
// Latency 1: a word loaded on an accept edge is valid the next cycle.
// Backpressure: req_ready = !out_valid | out_ready; a held word stays frozen until taken.
module lpm_mux_reg_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic           clk,
    input  logic           reset,
    lpm_mux_reg_n_if.slave bus
);
    typedef enum logic {ST_DIRECT, ST_SCAN} state_t;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] scan_ch_q, scan_ch_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_err_q, out_err_d;
    logic             out_valid_q, out_valid_d;

    logic             slot;
    logic             load;
    logic             load_err;
    logic [SEL_W-1:0] load_idx;
    logic [WIDTH-1:0] load_word;
    logic             sel_oob;

    assign slot    = !out_valid_q || bus.out_ready;
    assign sel_oob = (int'(bus.sel) >= CHANNELS);

    always_comb begin
        load_word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (load_idx == SEL_W'(k)) begin
                load_word = bus.data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = bus.mode ? ST_SCAN : ST_DIRECT;
        scan_ch_d   = scan_ch_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        load_idx    = scan_ch_q;
        load_err    = 1'b0;

        case (state_q)
            ST_DIRECT: begin
                load_idx = bus.sel;
                load_err = sel_oob;
                // Entering scan spends one idle cycle so the first scan word is always ch0.
                if (bus.mode) begin
                    scan_ch_d = '0;
                end else begin
                    load = bus.req_valid && slot;
                end
            end
            ST_SCAN: begin
                load = slot;
                if (slot) begin
                    scan_ch_d = (scan_ch_q == LAST_CH) ? '0 : scan_ch_q + SEL_W'(1);
                end
            end
            default: begin
            end
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = load_err ? '0 : load_word;
            out_ch_d    = load_idx;
            out_err_d   = load_err;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_DIRECT;
            scan_ch_q   <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_ch_q   <= scan_ch_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.req_ready = slot;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_lpm_mux_reg_n.sv
// Bench for lpm_mux_reg_n: a 4-channel and a 3-channel instance share one stimulus
// and are checked every cycle against a behavioural model, plus literal expectations.
module tb_lpm_mux_reg_n;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_w;
    logic [1:0]  sel;
    logic        mode;
    logic        req_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lpm_mux_reg_n_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) if_a ();
    lpm_mux_reg_n_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) if_b ();

    assign if_a.data_in   = data_w;
    assign if_b.data_in   = data_w[23:0];
    assign if_a.sel       = sel;
    assign if_b.sel       = sel;
    assign if_a.mode      = mode;
    assign if_b.mode      = mode;
    assign if_a.req_valid = req_valid;
    assign if_b.req_valid = req_valid;
    assign if_a.out_ready = out_ready;
    assign if_b.out_ready = out_ready;

    lpm_mux_reg_n #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave)
    );
    lpm_mux_reg_n #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the held word must be after the next rising edge.
    typedef struct {
        bit scan_mode;
        int scan;
        bit v;
        int d;
        int ch;
        bit e;
    } mdl_t;

    function automatic mdl_t mstep(mdl_t m, int c, bit rst, bit md, bit rv,
                                   int s, bit ordy, logic [31:0] din);
        mdl_t n = m;
        bit   slot = !m.v || ordy;
        bit   ld = 0;
        int   idx = 0;
        if (rst) begin
            n.scan_mode = 0; n.scan = 0; n.v = 0; n.d = 0; n.ch = 0; n.e = 0;
            return n;
        end
        if (!m.scan_mode && md) begin
            n.scan = 0;
        end else if (!m.scan_mode) begin
            if (rv && slot) begin ld = 1; idx = s; end
        end else if (slot) begin
            ld = 1; idx = m.scan; n.scan = (m.scan + 1) % c;
        end
        if (ld) begin
            n.v  = 1;
            n.ch = idx;
            n.e  = (idx >= c);
            n.d  = (idx >= c) ? 0 : int'((din >> (8 * idx)) & 32'hFF);
        end else if (ordy) begin
            n.v = 0;
        end
        n.scan_mode = md;
        return n;
    endfunction

    mdl_t ma, mb;
    bit   armed = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("a.out_valid", int'(if_a.out_valid), int'(ma.v));
            chk("b.out_valid", int'(if_b.out_valid), int'(mb.v));
            chk("a.req_ready", int'(if_a.req_ready), int'(!ma.v || out_ready));
            chk("b.req_ready", int'(if_b.req_ready), int'(!mb.v || out_ready));
            if (ma.v) begin
                chk("a.out_data", int'(if_a.out_data), ma.d);
                chk("a.out_ch",   int'(if_a.out_ch),   ma.ch);
                chk("a.out_err",  int'(if_a.out_err),  int'(ma.e));
            end
            if (mb.v) begin
                chk("b.out_data", int'(if_b.out_data), mb.d);
                chk("b.out_ch",   int'(if_b.out_ch),   mb.ch);
                chk("b.out_err",  int'(if_b.out_err),  int'(mb.e));
            end
        end
        if (reset) armed = 1;
        ma = mstep(ma, 4, reset, mode, req_valid, int'(sel), out_ready, data_w);
        mb = mstep(mb, 3, reset, mode, req_valid, int'(sel), out_ready, data_w);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; data_w = 32'h44332211; sel = 0; mode = 0; req_valid = 0; out_ready = 1;
        tick; tick;
        chk("rst a.valid", int'(if_a.out_valid), 0);
        chk("rst a.data",  int'(if_a.out_data),  0);
        chk("rst a.ch",    int'(if_a.out_ch),    0);
        chk("rst b.err",   int'(if_b.out_err),   0);
        reset = 0;
        tick;

        // Direct read of channel 2
        sel = 2; req_valid = 1;
        tick;
        chk("t1 a.valid", int'(if_a.out_valid), 1);
        chk("t1 a.data",  int'(if_a.out_data),  32'h33);
        chk("t1 a.ch",    int'(if_a.out_ch),    2);

        // Backpressure holds the word despite a new request
        out_ready = 0; sel = 0;
        #1;
        chk("t2 req_ready", int'(if_a.req_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t2 hold data",  int'(if_a.out_data),  32'h33);
            chk("t2 hold ready", int'(if_a.req_ready), 0);
        end
        out_ready = 1;
        #1;
        chk("t2 release ready", int'(if_a.req_ready), 1);
        tick;
        chk("t2 next data", int'(if_a.out_data), 32'h11);
        chk("t2 next ch",   int'(if_a.out_ch),   0);

        // Out-of-range select on the 3-channel instance
        sel = 3;
        tick;
        chk("t3 b.data", int'(if_b.out_data), 0);
        chk("t3 b.err",  int'(if_b.out_err),  1);
        chk("t3 b.ch",   int'(if_b.out_ch),   3);
        chk("t3 a.data", int'(if_a.out_data), 32'h44);
        chk("t3 a.err",  int'(if_a.out_err),  0);
        req_valid = 0;
        tick;
        chk("t3 drain", int'(if_a.out_valid), 0);

        // Enter scan: one idle cycle, then ch0, ch1, ...
        mode = 1;
        tick;
        chk("t4 idle", int'(if_a.out_valid), 0);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("t4 a.ch",   int'(if_a.out_ch),   i % 4);
            chk("t4 a.data", int'(if_a.out_data), ((i % 4) + 1) * 32'h11);
            chk("t4 b.ch",   int'(if_b.out_ch),   i % 3);
            chk("t4 b.data", int'(if_b.out_data), ((i % 3) + 1) * 32'h11);
        end

        // Toggling out_ready while scanning
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2 == 0);
            tick;
        end

        // Reset while a word is held
        out_ready = 0;
        tick;
        reset = 1;
        tick;
        chk("t6 a.valid", int'(if_a.out_valid), 0);
        chk("t6 a.data",  int'(if_a.out_data),  0);
        chk("t6 b.valid", int'(if_b.out_valid), 0);
        reset = 0; out_ready = 1;
        tick;
        chk("t6 idle", int'(if_a.out_valid), 0);
        tick;
        chk("t6 a.ch0",   int'(if_a.out_ch),   0);
        chk("t6 a.data0", int'(if_a.out_data), 32'h11);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            data_w    = $urandom;
            sel       = 2'($urandom_range(0, 3));
            req_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            reset     = ($urandom_range(0, 99) == 0);
            tick;
        end
        reset = 0;
        tick; tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
